lfsr_pattern_gen: RTL
=====================

// Module: lfsr_pattern_gen
// PURPOSE
//  Parametrised LED pattern generator for the board LED_Patterns project.
//  A WIDTH-bit Fibonacci LFSR with programmable taps advances on a divided
//  tick or on a single-step pulse. Its state maps to the LED bus through a
//  display mode: raw, bar graph or sparkle, with optional inversion.
//  Also supports runtime seed load, speed select and a period-wrap flag.
// PARAMETERS
//  WIDTH     10      LFSR and LED bus width, 4..16
//  DIV_BITS  20      tick divider width, >= 8
//  TAPS      10'h240 feedback tap mask [WIDTH-1:0]; default = bits 9,6 (maximal)
//  SEED      10'h001 reset seed; must be non-zero
// PORTS
//  clk       in   1      system clock
//  rst_n     in   1      asynchronous reset, active-low
//  en        in   1      run enable for divider/auto-advance
//  step      in   1      single-cycle advance request, independent of en
//  load      in   1      load seed_in into LFSR and seed register
//  seed_in   in   WIDTH  runtime seed
//  speed     in   2      divider select, 0 = slowest, 3 = fastest
//  mode      in   2      0 raw, 1 bar, 2 sparkle, 3 hold
//  dir       in   1      1 = invert pattern output
//  pattern   out  WIDTH  LED drive, registered
//  tick_o    out  1      1-cycle pulse: an advance occurred last cycle
//  wrap      out  1      1-cycle pulse: LFSR returned to seed value
// BEHAVIOUR
//  Reset (async, rst_n=0):
//   - lfsr = SEED, seed_reg = SEED, prev = 0, div = 0.
//   - pattern = 0, tick_o = 0, wrap = 0.
//  Divider:
//   - Counts only when en = 1; holds when en = 0.
//   - tc is true when div == 2^(DIV_BITS-2*speed) - 1; div returns to 0 on tc.
//   - A speed change mid-count with div above the new tc: div wraps naturally at DIV_BITS.
//  Advance:
//   - adv = (en & tc) | step; at most one advance per cycle.
//  Next state:
//   - fb = ^(lfsr & TAPS); nxt = {lfsr[WIDTH-2:0], fb}.
//   - If nxt == 0, use 1 instead (lock-up guard).
//   - On adv: prev <= lfsr, lfsr <= nxt.
//  Load:
//   - load has priority over adv in the same cycle; that adv is dropped.
//   - v = (seed_in == 0) ? 1 : seed_in.
//   - lfsr <= v, seed_reg <= v, prev <= 0, div <= 0.
//  Pattern (registered every cycle from current regs, 1-cycle latency):
//   - mode 0: p = lfsr.
//   - mode 1: p = (1 << popcount(lfsr)) - 1, saturating to all-ones at WIDTH.
//   - mode 2: p = lfsr & prev.
//   - mode 3: p holds the last displayed pattern; the LFSR keeps advancing.
//   - pattern <= dir ? ~p : p. In mode 3, dir is already applied to the held value.
//  Flags:
//   - tick_o <= adv & ~load.
//   - wrap <= adv & ~load & (nxt == seed_reg).
//   - With maximal taps, wrap asserts once every 2^WIDTH - 1 advances.
//  Mode/dir/speed changes take effect on the next clock, with no glitch or restart.
// TESTING (WIDTH=10, DIV_BITS=8, defaults)
//  1 Reset release, en=0, step pulses x8.
//    -> lfsr 001,002,004,008,010,020,040,081.
//    -> pattern follows one cycle later; tick_o pulses x8.
//  2 en=1, speed=0 -> tick_o every 256 cycles; speed=3 -> every 4 cycles.
//    en=0 mid-count -> no ticks, div holds.
//  3 Free-run with speed=3.
//    -> wrap pulses exactly once per 1023 advances, when lfsr returns to 001.
//  4 lfsr=081: mode1 -> pattern 003; dir=1 -> 3FC; mode2 (prev=040) -> 000.
//    mode3, then 5 steps -> pattern unchanged.
//  5 load=1 with seed_in=000 and step=1 in the same cycle.
//    -> lfsr=001, no tick_o, seed_reg=001.
//    load seed_in=155, then 1023 steps -> wrap on return to 155.
//  6 rst_n low asynchronously mid-run (between edges).
//    -> pattern/tick_o/wrap = 0 immediately; lfsr = 001 after release.

Source files
------------

// File: rtl/lfsr_pattern_gen.sv
// ---------------------------------------------------------------------------
// lfsr_pattern_gen
//
// LED pattern generator. A WIDTH-bit Fibonacci LFSR with a programmable tap
// mask advances either on a divided tick (while enabled) or on a single-step
// request. Its state is mapped onto the LED bus through a display mode (raw,
// bar graph, sparkle or hold), with optional inversion. The seed can be
// reloaded at runtime, and a wrap flag pulses when the sequence comes back to
// the current seed.
//
// Parameters
//   WIDTH     LFSR and LED bus width, 4..16
//   DIV_BITS  tick divider width, >= 8
//   TAPS      feedback tap mask (bit i set = lfsr[i] feeds the XOR)
//   SEED      reset seed, must be non-zero
//
// Ports
//   clk       system clock
//   rst_n     asynchronous reset, active-low
//   en        run enable for divider / auto-advance
//   step      single-cycle advance request, independent of en
//   load      load seed_in into the LFSR and the seed register
//   seed_in   runtime seed (zero is replaced by 1)
//   speed     divider select, 0 = slowest, 3 = fastest
//   mode      0 raw, 1 bar graph, 2 sparkle, 3 hold
//   dir       1 = invert pattern output
//   pattern   LED drive, registered (one cycle behind the LFSR state)
//   tick_o    one-cycle pulse: an advance occurred last cycle
//   wrap      one-cycle pulse: the LFSR returned to the seed value
// ---------------------------------------------------------------------------
module lfsr_pattern_gen #(
  parameter int               WIDTH    = 10,
  parameter int               DIV_BITS = 20,
  parameter logic [WIDTH-1:0] TAPS     = WIDTH'(10'h240),
  parameter logic [WIDTH-1:0] SEED     = WIDTH'(10'h001)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             step,
  input  logic             load,
  input  logic [WIDTH-1:0] seed_in,
  input  logic [1:0]       speed,
  input  logic [1:0]       mode,
  input  logic             dir,
  output logic [WIDTH-1:0] pattern,
  output logic             tick_o,
  output logic             wrap
);

  // All-ones divider value; shifting it right by 2*speed gives the terminal
  // count 2^(DIV_BITS-2*speed)-1 without any arithmetic.
  localparam logic [DIV_BITS-1:0] DIV_ONES = {DIV_BITS{1'b1}};
  localparam logic [WIDTH-1:0]    ONE_W    = WIDTH'(1'b1);
  localparam logic [WIDTH-1:0]    ZERO_W   = {WIDTH{1'b0}};

  // Even/odd parity of a word: the XOR of all its bits.
  function automatic logic parity_f(input logic [WIDTH-1:0] v);
    parity_f = ^v;
  endfunction

  // Number of set bits in a word (WIDTH <= 16, so 5 bits are enough).
  function automatic logic [4:0] popcount_f(input logic [WIDTH-1:0] v);
    logic [4:0] cnt;
    cnt = 5'd0;
    for (int i = 0; i < WIDTH; i++) begin
      cnt = cnt + 5'(v[i]);
    end
    popcount_f = cnt;
  endfunction

  // Thermometer code with popcount(v) low bits set. Setting bit i whenever
  // the count exceeds i gives (1 << n) - 1 and saturates to all-ones for free.
  function automatic logic [WIDTH-1:0] bar_f(input logic [WIDTH-1:0] v);
    logic [4:0]       cnt;
    logic [WIDTH-1:0] bar;
    cnt = popcount_f(v);
    for (int i = 0; i < WIDTH; i++) begin
      bar[i] = (int'(cnt) > i);
    end
    bar_f = bar;
  endfunction

  logic [WIDTH-1:0]    lfsr_r;
  logic [WIDTH-1:0]    prev_r;
  logic [WIDTH-1:0]    seed_r;
  logic [DIV_BITS-1:0] div_r;

  logic [DIV_BITS-1:0] tc_val_s;
  logic                tc_s;
  logic                adv_s;
  logic [WIDTH-1:0]    shift_s;
  logic [WIDTH-1:0]    nxt_s;
  logic [WIDTH-1:0]    seed_v_s;
  logic [WIDTH-1:0]    disp_s;
  logic [WIDTH-1:0]    pat_nxt_s;

  // Divider terminal count and advance request.
  always_comb begin
    tc_val_s = DIV_ONES >> {speed, 1'b0};
    tc_s     = (div_r == tc_val_s);
    adv_s    = (en & tc_s) | step;
  end

  // LFSR next state with lock-up guard, and sanitised runtime seed.
  always_comb begin
    shift_s = {lfsr_r[WIDTH-2:0], parity_f(lfsr_r & TAPS)};
    if (shift_s == ZERO_W) begin
      nxt_s = ONE_W;
    end else begin
      nxt_s = shift_s;
    end
    if (seed_in == ZERO_W) begin
      seed_v_s = ONE_W;
    end else begin
      seed_v_s = seed_in;
    end
  end

  // Display mapping; hold mode keeps the already-inverted registered value.
  always_comb begin
    disp_s    = lfsr_r;
    pat_nxt_s = pattern;
    case (mode)
      2'd0: disp_s = lfsr_r;
      2'd1: disp_s = bar_f(lfsr_r);
      2'd2: disp_s = lfsr_r & prev_r;
      default: disp_s = lfsr_r;
    endcase
    if (mode == 2'd3) begin
      pat_nxt_s = pattern;
    end else if (dir) begin
      pat_nxt_s = ~disp_s;
    end else begin
      pat_nxt_s = disp_s;
    end
  end

  // LFSR, history, seed and divider state. A load wins over any advance in
  // the same cycle and also restarts the divider.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_r <= SEED;
      prev_r <= ZERO_W;
      seed_r <= SEED;
      div_r  <= {DIV_BITS{1'b0}};
    end else if (load) begin
      lfsr_r <= seed_v_s;
      prev_r <= ZERO_W;
      seed_r <= seed_v_s;
      div_r  <= {DIV_BITS{1'b0}};
    end else begin
      if (adv_s) begin
        prev_r <= lfsr_r;
        lfsr_r <= nxt_s;
      end
      // After a speed change the count may already be past the new terminal
      // value; it then simply rolls over at DIV_BITS.
      if (en) begin
        if (tc_s) begin
          div_r <= {DIV_BITS{1'b0}};
        end else begin
          div_r <= div_r + DIV_BITS'(1);
        end
      end
    end
  end

  // Registered outputs: LED pattern and event pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pattern <= ZERO_W;
      tick_o  <= 1'b0;
      wrap    <= 1'b0;
    end else begin
      pattern <= pat_nxt_s;
      tick_o  <= adv_s & ~load;
      wrap    <= adv_s & ~load & (nxt_s == seed_r);
    end
  end

endmodule
